// File: rtl/pipe_if_id.sv
// IF/ID pipeline register with load-use hazard detection, branch-flush NOP
// injection and a saturating stall-cycle counter for performance debug.
module pipe_if_id #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instruction_i,
  input  logic             flush_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_addr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instruction_o,
  output logic             valid_o,
  output logic [4:0]       rs_addr_o,
  output logic [4:0]       rt_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic             ctrl_nop_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard_c;
  logic             src_match_c;

  // Both source fields are compared regardless of format; x0 never stalls.
  always_comb begin
    src_match_c = (ex_rd_addr_i == instr_q[19:15]) || (ex_rd_addr_i == instr_q[24:20]);
    hazard_c    = valid_q && ex_mem_read_i && (ex_rd_addr_i != 5'd0) && src_match_c;
  end

  // Next state: flush beats stall beats normal load.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      pc_d    = pc_i;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hazard_c) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      pc_d    = pc_i;
      instr_d = instruction_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;
  assign rs_addr_o     = instr_q[19:15];
  assign rt_addr_o     = instr_q[24:20];
  assign rd_addr_o     = instr_q[11:7];
  assign stall_cnt_o   = cnt_q;
  assign stall_o       = hazard_c;
  assign pc_write_o    = ~hazard_c | flush_i;
  assign ctrl_nop_o    = hazard_c | ~valid_q;

endmodule

// File: tb/tb_pipe_if_id.sv
// Scoreboard bench for pipe_if_id: directed vectors push expected snapshots,
// a decoupled monitor pops and compares them against the DUT outputs.
module tb_pipe_if_id;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        pcw;
    logic        nop;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i = '0, instruction_i = '0;
  logic        flush_i = 1'b0, ex_mem_read_i = 1'b0;
  logic [4:0]  ex_rd_addr_i = '0;

  logic [31:0] pc_o, instruction_o, pc2_o, instruction2_o;
  logic        valid_o, stall_o, pc_write_o, ctrl_nop_o;
  logic        valid2_o, stall2_o, pc_write2_o, ctrl_nop2_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o, rs2_o, rt2_o, rd2_o;
  logic [15:0] stall_cnt_o;
  logic [1:0]  stall_cnt2_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk_i = ~clk_i;

  pipe_if_id dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instruction_i(instruction_i),
    .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_addr_i(ex_rd_addr_i),
    .pc_o(pc_o), .instruction_o(instruction_o), .valid_o(valid_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .stall_o(stall_o), .pc_write_o(pc_write_o), .ctrl_nop_o(ctrl_nop_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // Narrow-counter instance for the saturation check.
  pipe_if_id #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instruction_i(instruction_i),
    .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_addr_i(ex_rd_addr_i),
    .pc_o(pc2_o), .instruction_o(instruction2_o), .valid_o(valid2_o),
    .rs_addr_o(rs2_o), .rt_addr_o(rt2_o), .rd_addr_o(rd2_o),
    .stall_o(stall2_o), .pc_write_o(pc_write2_o), .ctrl_nop_o(ctrl_nop2_o),
    .stall_cnt_o(stall_cnt2_o)
  );

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step%0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  // Apply one vector at the falling edge; the expectation describes the
  // registered state from earlier edges plus combinational outputs now.
  task automatic vec(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                     input logic fl, input logic mr, input logic [4:0] rd,
                     input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_v,
                     input logic e_st, input logic e_pw, input logic e_nop,
                     input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
    exp_t e;
    @(negedge clk_i);
    rst_i = rst; pc_i = pc; instruction_i = ins; flush_i = fl;
    ex_mem_read_i = mr; ex_rd_addr_i = rd;
    e.pc = e_pc; e.instr = e_ins; e.valid = e_v; e.stall = e_st; e.pcw = e_pw;
    e.nop = e_nop; e.cnt = e_cnt; e.cnt2 = e_cnt2;
    exp_q.push_back(e);
  endtask

  // Monitor: snapshot every falling edge (after inputs settle) while work is queued.
  initial begin
    int step = 0;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] ei;
        e  = exp_q.pop_front();
        ei = e.instr;
        chk("pc_o", step, pc_o, e.pc);
        chk("instruction_o", step, instruction_o, e.instr);
        chk("valid_o", step, 32'(valid_o), 32'(e.valid));
        chk("rs_addr_o", step, 32'(rs_addr_o), 32'(ei[19:15]));
        chk("rt_addr_o", step, 32'(rt_addr_o), 32'(ei[24:20]));
        chk("rd_addr_o", step, 32'(rd_addr_o), 32'(ei[11:7]));
        chk("stall_o", step, 32'(stall_o), 32'(e.stall));
        chk("pc_write_o", step, 32'(pc_write_o), 32'(e.pcw));
        chk("ctrl_nop_o", step, 32'(ctrl_nop_o), 32'(e.nop));
        chk("stall_cnt_o", step, 32'(stall_cnt_o), 32'(e.cnt));
        chk("stall_cnt_sat", step, 32'(stall_cnt2_o), 32'(e.cnt2));
        step++;
      end
    end
  end

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD  = 32'h0020_8033;  // rs1=1 rs2=2 rd=0
  localparam logic [31:0] LU5  = 32'h0002_8293;  // addi x5,x5,0
  localparam logic [31:0] ADI1 = 32'h0010_0093;  // addi x1,x0,1

  initial begin
    // rst pc ins fl mr rd | pc instr v stall pcw nop cnt cnt2
    vec(1, 32'h0,   32'h0,  0, 0, 5'd0, 32'h0,   NOP,  0, 0, 1, 1, 16'd0, 2'd0);
    vec(1, 32'h0,   32'h0,  0, 0, 5'd0, 32'h0,   NOP,  0, 0, 1, 1, 16'd0, 2'd0);
    vec(0, 32'h4,   ADD,    0, 0, 5'd0, 32'h0,   NOP,  0, 0, 1, 1, 16'd0, 2'd0);
    vec(0, 32'h8,   LU5,    0, 0, 5'd0, 32'h4,   ADD,  1, 0, 1, 0, 16'd0, 2'd0);
    // load-use on rs1=5: hold, then resume
    vec(0, 32'hc,   ADI1,   0, 1, 5'd5, 32'h8,   LU5,  1, 1, 0, 1, 16'd0, 2'd0);
    vec(0, 32'hc,   ADI1,   0, 0, 5'd5, 32'h8,   LU5,  1, 0, 1, 0, 16'd1, 2'd1);
    // x0 destination with rs1=0 never stalls
    vec(0, 32'h10,  LU5,    0, 1, 5'd0, 32'hc,   ADI1, 1, 0, 1, 0, 16'd1, 2'd1);
    // stall and flush together: flush wins, counter untouched
    vec(0, 32'h100, 32'hdeadbeef, 1, 1, 5'd5, 32'h10, LU5, 1, 1, 1, 1, 16'd1, 2'd1);
    vec(0, 32'h104, ADD,    0, 0, 5'd0, 32'h100, NOP,  0, 0, 1, 1, 16'd1, 2'd1);
    vec(0, 32'h108, LU5,    0, 0, 5'd0, 32'h104, ADD,  1, 0, 1, 0, 16'd1, 2'd1);
    // reset asserted mid-stall
    vec(1, 32'h10c, NOP,    0, 1, 5'd5, 32'h108, LU5,  1, 1, 0, 1, 16'd1, 2'd1);
    vec(0, 32'h200, LU5,    0, 1, 5'd5, 32'h0,   NOP,  0, 0, 1, 1, 16'd0, 2'd0);
    // five consecutive stall edges: narrow counter 1,2,3,3,3
    vec(0, 32'h204, NOP,    0, 1, 5'd5, 32'h200, LU5,  1, 1, 0, 1, 16'd0, 2'd0);
    vec(0, 32'h204, NOP,    0, 1, 5'd5, 32'h200, LU5,  1, 1, 0, 1, 16'd1, 2'd1);
    vec(0, 32'h204, NOP,    0, 1, 5'd5, 32'h200, LU5,  1, 1, 0, 1, 16'd2, 2'd2);
    vec(0, 32'h204, NOP,    0, 1, 5'd5, 32'h200, LU5,  1, 1, 0, 1, 16'd3, 2'd3);
    vec(0, 32'h204, NOP,    0, 1, 5'd5, 32'h200, LU5,  1, 1, 0, 1, 16'd4, 2'd3);
    vec(1, 32'h204, NOP,    0, 1, 5'd5, 32'h200, LU5,  1, 1, 0, 1, 16'd5, 2'd3);
    vec(0, 32'h0,   NOP,    0, 0, 5'd0, 32'h0,   NOP,  0, 0, 1, 1, 16'd0, 2'd0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    #5;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
